// File: rtl/fpu_seq_ctrl.sv
// Sequencer for one in-flight FP op: issue, optional wait on the datapath, then a single write-back strobe.
// Optional FPU_TIMEOUT_EN adds a WAIT-state watchdog that sets a sticky timeout_err after TIMEOUT cycles.
module fpu_seq_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fpu_en,
  input  logic [4:0] func5,
  input  logic [4:0] rd,
  input  logic       flush,
  input  logic       fpu_done,
  output logic       fpu_start,
  output logic       stall,
  output logic       busy,
  output logic       wb_int_en,
  output logic       wb_fp_en,
  output logic [4:0] wb_rd,
  output logic       timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

  state_t     state;
  logic [4:0] func_q;
  logic       kill;
  logic       single_cyc;
  logic       int_dst;
  logic       drop;

  always_comb begin
    single_cyc = func_q inside {5'b00100, 5'b00101, 5'b10100, 5'b11100, 5'b11110};
    int_dst    = func_q inside {5'b11100, 5'b11000, 5'b10100};
    // a flush arriving in the same cycle as the WB transition still suppresses the strobe
    drop       = kill | flush;
  end

  assign busy  = (state != IDLE);
  assign stall = ((state == IDLE) & fpu_en) | (state == ISSUE) | (state == WAIT);

`ifdef FPU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign timeout_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      func_q    <= '0;
      kill      <= 1'b0;
      fpu_start <= 1'b0;
      wb_int_en <= 1'b0;
      wb_fp_en  <= 1'b0;
      wb_rd     <= '0;
`ifdef FPU_TIMEOUT_EN
      cnt         <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      fpu_start <= 1'b0;
      wb_int_en <= 1'b0;
      wb_fp_en  <= 1'b0;
      case (state)
        IDLE: begin
          if (fpu_en && !flush) begin
            func_q    <= func5;
            wb_rd     <= rd;
            kill      <= 1'b0;
            fpu_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (flush) kill <= 1'b1;
`ifdef FPU_TIMEOUT_EN
          cnt <= '0;
`endif
          if (single_cyc) begin
            wb_int_en <= int_dst & ~drop;
            wb_fp_en  <= ~int_dst & ~drop;
            state     <= WB;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (flush) kill <= 1'b1;
          if (fpu_done) begin
            wb_int_en <= int_dst & ~drop;
            wb_fp_en  <= ~int_dst & ~drop;
            state     <= WB;
          end
`ifdef FPU_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            kill        <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        WB: begin
          kill  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// Directed bench for fpu_seq_ctrl; outputs are sampled 1ns after the falling edge, once inputs settle.
module tb_fpu_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       fpu_en, flush, fpu_done;
  logic [4:0] func5, rd;
  logic       fpu_start, stall, busy, wb_int_en, wb_fp_en, timeout_err;
  logic [4:0] wb_rd;

  int checks = 0;
  int errors = 0;

  fpu_seq_ctrl #(.TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .fpu_en(fpu_en), .func5(func5), .rd(rd),
    .flush(flush), .fpu_done(fpu_done), .fpu_start(fpu_start), .stall(stall),
    .busy(busy), .wb_int_en(wb_int_en), .wb_fp_en(wb_fp_en), .wb_rd(wb_rd),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // advance to the next cycle's sample point with the given inputs applied
  task automatic cyc(input logic en, input logic [4:0] f, input logic [4:0] r,
                     input logic fl, input logic dn);
    @(negedge clk);
    fpu_en = en; func5 = f; rd = r; flush = fl; fpu_done = dn;
    #1;
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // {fpu_start, stall, busy, wb_int_en, wb_fp_en}
  function automatic int outs();
    return int'({fpu_start, stall, busy, wb_int_en, wb_fp_en});
  endfunction

  initial begin
    rst_n = 1'b0; fpu_en = 1'b0; func5 = '0; rd = '0; flush = 1'b0; fpu_done = 1'b0;
    idle_cyc();
    chk("reset_outs", outs(), 5'b00000);
    chk("reset_rd", int'(wb_rd), 0);
    chk("reset_tmo", int'(timeout_err), 0);
    @(negedge clk); rst_n = 1'b1;
    idle_cyc();

    // fsgnj, single-cycle, FP destination
    cyc(1'b1, 5'b00100, 5'd5, 1'b0, 1'b0); chk("sgl_c0", outs(), 5'b01000);
    idle_cyc();                            chk("sgl_c1", outs(), 5'b11100);
    idle_cyc();                            chk("sgl_c2", outs(), 5'b00101);
    chk("sgl_rd", int'(wb_rd), 5);
    idle_cyc();                            chk("sgl_c3", outs(), 5'b00000);

    // fcvt.w.s, multi-cycle, integer destination, done at cycle 6
    cyc(1'b1, 5'b11000, 5'd9, 1'b0, 1'b0); chk("cvt_c0", outs(), 5'b01000);
    idle_cyc();                            chk("cvt_c1", outs(), 5'b11100);
    for (int i = 2; i <= 5; i++) begin
      idle_cyc();                          chk("cvt_wait", outs(), 5'b01100);
    end
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b1);     chk("cvt_c6", outs(), 5'b01100);
    idle_cyc();                            chk("cvt_c7", outs(), 5'b00110);
    chk("cvt_rd", int'(wb_rd), 9);
    idle_cyc();                            chk("cvt_c8", outs(), 5'b00000);

    // fdiv with flush at cycle 3, done at cycle 10
    cyc(1'b1, 5'b00011, 5'd3, 1'b0, 1'b0);
    idle_cyc(); idle_cyc();
    cyc(1'b0, 5'd0, 5'd0, 1'b1, 1'b0);     chk("div_c3", outs(), 5'b01100);
    for (int i = 4; i <= 9; i++) idle_cyc();
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b1);     chk("div_c10", outs(), 5'b01100);
    idle_cyc();                            chk("div_c11", outs(), 5'b00100);
    idle_cyc();                            chk("div_c12", outs(), 5'b00000);

    // fpu_done in IDLE is ignored
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
    idle_cyc();                            chk("done_idle", outs(), 5'b00000);
    // fpu_done in ISSUE does not skip WAIT
    cyc(1'b1, 5'b00000, 5'd2, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b1);     chk("done_iss_c1", outs(), 5'b11100);
    idle_cyc();                            chk("done_iss_c2", outs(), 5'b01100);
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
    // fpu_en during WB is held off until IDLE; stall stays low in WB
    cyc(1'b1, 5'b00101, 5'd11, 1'b0, 1'b0); chk("wb_hold", outs(), 5'b00101);
    chk("wb_hold_rd", int'(wb_rd), 2);
    cyc(1'b1, 5'b00101, 5'd11, 1'b0, 1'b0); chk("late_acc", outs(), 5'b01000);
    idle_cyc();                            chk("late_iss", outs(), 5'b11100);
    chk("late_rd", int'(wb_rd), 11);
    idle_cyc();                            chk("late_wb", outs(), 5'b00101);
    // fpu_en with flush in IDLE is not accepted
    cyc(1'b1, 5'b10100, 5'd7, 1'b1, 1'b0); chk("flush_idle", outs(), 5'b01000);
    idle_cyc();                            chk("flush_idle_n", outs(), 5'b00000);
    // single-cycle integer op with done during ISSUE
    cyc(1'b1, 5'b10100, 5'd7, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
    idle_cyc();                            chk("fmv_wb", outs(), 5'b00110);

    // reset during WAIT, then a stray fpu_done
    cyc(1'b1, 5'b00001, 5'd4, 1'b0, 1'b0);
    idle_cyc(); idle_cyc();                chk("rst_pre", outs(), 5'b01100);
    rst_n = 1'b0; #1;
    chk("rst_async", outs(), 5'b00000);
    chk("rst_async_rd", int'(wb_rd), 0);
    @(negedge clk); rst_n = 1'b1;
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
    idle_cyc();                            chk("rst_post", outs(), 5'b00000);
    chk("rst_post_rd", int'(wb_rd), 0);

    // WAIT with no fpu_done
    cyc(1'b1, 5'b00011, 5'd6, 1'b0, 1'b0);
    idle_cyc();
`ifdef FPU_TIMEOUT_EN
    for (int i = 2; i <= 9; i++) idle_cyc();
    chk("tmo_c9", outs(), 5'b01100);
    chk("tmo_c9_err", int'(timeout_err), 0);
    idle_cyc();                            chk("tmo_c10", outs(), 5'b00000);
    chk("tmo_c10_err", int'(timeout_err), 1);
    for (int i = 0; i < 5; i++) idle_cyc();
    chk("tmo_sticky", int'(timeout_err), 1);
    @(negedge clk); rst_n = 1'b0; #1;
    chk("tmo_rst", int'(timeout_err), 0);
    @(negedge clk); rst_n = 1'b1;
`else
    for (int i = 0; i < 30; i++) idle_cyc();
    chk("nowd_wait", outs(), 5'b01100);
    chk("nowd_err", int'(timeout_err), 0);
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
    idle_cyc();                            chk("nowd_wb", outs(), 5'b00101);
    chk("nowd_rd", int'(wb_rd), 6);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpu_seq_ctrl.md
FPU_SEQ_CTRL -- requirements
Module: fpu_seq_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: WAIT-state cycle limit, used only when FPU_TIMEOUT_EN is defined.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port fpu_en, input, 1 bit: decoded floating-point op (opcode 1010011) valid.
REQ-005 SHALL have port func5, input, 5 bits: instr[31:27] of that op.
REQ-006 SHALL have port rd, input, 5 bits: destination register index.
REQ-007 SHALL have port flush, input, 1 bit: pipeline kill of the in-flight op.
REQ-008 SHALL have port fpu_done, input, 1 bit: FPU datapath result-valid pulse.
REQ-009 SHALL have port fpu_start, output, 1 bit: one-cycle FPU launch pulse.
REQ-010 SHALL have port stall, output, 1 bit: hold the front pipeline stages.
REQ-011 SHALL have port busy, output, 1 bit: high when the state is not IDLE.
REQ-012 SHALL have port wb_int_en, output, 1 bit: integer register-file write strobe.
REQ-013 SHALL have port wb_fp_en, output, 1 bit: FP register-file write strobe.
REQ-014 SHALL have port wb_rd, output, 5 bits: captured destination index.
REQ-015 SHALL have port timeout_err, output, 1 bit: sticky FPU-hang flag.

Function
REQ-016 SHALL implement the states IDLE, ISSUE, WAIT and WB.
REQ-017 SHALL, in IDLE with fpu_en=1 and flush=0, capture func5 and rd and go to ISSUE; in IDLE with fpu_en=1 and flush=1, stay in IDLE.
REQ-018 SHALL assert fpu_start only in ISSUE, for exactly one cycle per accepted op.
REQ-019 SHALL classify the captured func5 values 00100, 00101, 10100, 11100 and 11110 as single-cycle: ISSUE goes to WB. All other func5 values SHALL be multi-cycle: ISSUE goes to WAIT.
REQ-020 SHALL ignore fpu_done in IDLE and ISSUE; in WAIT, fpu_done=1 SHALL move the state to WB on the next edge.
REQ-021 SHALL, in WB, pulse exactly one write strobe for one cycle and then return to IDLE: wb_int_en for captured func5 11100, 11000 or 10100, otherwise wb_fp_en.
REQ-022 SHALL drive stall as a combinational signal: (IDLE and fpu_en) or ISSUE or WAIT. stall SHALL be low in WB.
REQ-023 SHALL hold wb_rd at the captured rd from acceptance until the next acceptance.
REQ-024 SHALL, when flush=1 in ISSUE or WAIT, set an internal kill flag. The sequence SHALL still complete (the FPU cannot abort), but WB SHALL drive no strobe; the kill flag SHALL clear on return to IDLE.
REQ-025 SHALL give the following latency, with acceptance at cycle 0: fpu_start at cycle 1; a single-cycle op strobes at cycle 2; a multi-cycle op with fpu_done at cycle k strobes at cycle k+1.
REQ-026 SHALL not accept a new op while in WB. fpu_en asserted in WB is taken in the following IDLE cycle.

Reset
REQ-027 SHALL, on rst_n=0, immediately force state IDLE, clear the kill flag and counter, and drive fpu_start, stall (excluding the fpu_en term), busy, wb_int_en, wb_fp_en, wb_rd and timeout_err to 0.
REQ-028 SHALL, on reset mid-operation, drop the op with no strobe; a later fpu_done SHALL be ignored.

Configuration
REQ-029 SHALL, with FPU_TIMEOUT_EN defined, count WAIT cycles. When the count reaches TIMEOUT without fpu_done, the block SHALL set timeout_err (sticky until reset), return to IDLE, and drive no strobe.
REQ-030 SHALL, without FPU_TIMEOUT_EN, include no counter, tie timeout_err to 0, and allow WAIT to persist indefinitely.

Verification
REQ-031 SHALL cover: fpu_en with func5=00100 (fsgnj), rd=5 at cycle 0 -> fpu_start at cycle 1, wb_fp_en=1 with wb_rd=5 at cycle 2, stall high in cycles 0-1 only.
REQ-032 SHALL cover: func5=11000 (fcvt.w.s), rd=9, fpu_done at cycle 6 -> wb_int_en=1 at cycle 7, stall high in cycles 0-6.
REQ-033 SHALL cover: func5=00011 (fdiv), flush at cycle 3, fpu_done at cycle 10 -> no strobe, busy low at cycle 12.
REQ-034 SHALL cover: rst_n low during WAIT, then fpu_done pulse -> state IDLE, no strobe, all outputs 0.
REQ-035 SHALL cover, with FPU_TIMEOUT_EN and TIMEOUT=8: multi-cycle op with no fpu_done -> timeout_err=1 after 8 WAIT cycles, held high until reset, no strobe.
REQ-036 SHALL cover: fpu_done in IDLE and in ISSUE -> no state change and no strobe.
